decode_issue: RTL and testbench
===============================

# decode_issue

Instruction decode and operand-issue stage that sits upstream of the ALU and drives its complete input bundle: opcode, SRC, TARG, immediateVal, funct, shamt and pc. It accepts fetched instructions over a valid/ready handshake and reads operands from an internal 32x32 register file, with write-back bypass. A per-register scoreboard stalls read-after-write and write-after-write hazards, and results are held in a registered output stage with its own valid/ready handshake toward execute.

## Interface
Parameters:
- `NREG`, 32: register count (fixed at 32; r0 reads as zero).
- `XLEN`, 32: datapath width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_valid`  in  1  fetch presents an instruction.
- `if_ready`  out  1  stage accepts the instruction this cycle.
- `if_instr`  in  32  instruction word.
- `if_pc`  in  32  PC of `if_instr`.
- `wb_en`  in  1  write-back strobe.
- `wb_addr`  in  5  write-back register.
- `wb_data`  in  32  write-back value.
- `flush`  in  1  kill the held output instruction.
- `ex_valid`  out  1  output bundle valid.
- `ex_ready`  in  1  execute consumes the bundle.
- `opcode`  out  32  `instr[31:26]`, zero-extended.
- `SRC`  out  32  rs operand.
- `TARG`  out  32  rt operand.
- `immediateVal`  out  32  extended immediate.
- `funct`  out  6  `instr[5:0]`.
- `shamt`  out  5  `instr[10:6]`.
- `pc`  out  32  instruction PC.
- `dest_addr`  out  5  destination register.
- `dest_we`  out  1  instruction writes `dest_addr`.
- `mem_read`, `mem_write`  out  1 each  LW / SW.
- `illegal`  out  1  unsupported encoding.

## Operation
- Supported opcodes:
  - `0x00` R-type, funct `0x20`/`0x22`/`0x24`/`0x25`/`0x26`/`0x2A`/`0x00`/`0x02`; any other funct is illegal.
  - `0x02` J, `0x08` ADDI, `0x0C` ANDI, `0x23` LW, `0x2B` SW, `0x04` BEQ, `0x05` BNE.
  - All other opcodes are illegal.
- Immediate extension:
  - Sign-extend `instr[15:0]` for ADDI, LW, SW, BEQ, BNE.
  - Zero-extend `instr[15:0]` for ANDI.
  - Zero-extend `instr[25:0]` for J.
  - 0 for R-type.
- Destination:
  - R-type writes `rd` (`instr[15:11]`).
  - ADDI, ANDI and LW write `rt` (`instr[20:16]`).
  - SW, BEQ, BNE, J and illegal encodings set `dest_we=0`.
  - `dest_we` is forced to 0 when the destination is r0.
- Register file: r0 always reads 0. If `wb_en` is set and `wb_addr==rs` (or rt) and the register is nonzero, the read returns `wb_data` in the same cycle (bypass). Writes to r0 are ignored.
- Scoreboard `pend[31:0]`:
  - Set on issue of an instruction with `dest_we`.
  - Cleared by `wb_en` at `wb_addr`.
  - If a clear and a set hit the same register in one cycle, the set wins.
- Hazard: raised if any used source register (rs for all except J; rt for R-type, SW, BEQ, BNE) or the destination has `pend=1` and is not being cleared by `wb_en` this cycle.
- `if_ready = (~ex_valid | ex_ready) & ~hazard & ~flush`. Transfer occurs when `if_valid & if_ready`.
- Flush:
  - Clears `ex_valid`.
  - If the held instruction had `dest_we`, clears its `pend` bit.
  - No transfer takes place that cycle.
- Illegal instructions are issued with `illegal=1`, `dest_we=0`, `mem_read=mem_write=0`.

## Timing
- Reset: all outputs are 0 (`ex_valid=0`), `pend=0`, and all registers are 0.
- Decode latency is 1 cycle: an instruction transferred at edge N is presented with `ex_valid=1` after edge N.
- The output bundle holds stable while `ex_valid & ~ex_ready`.
- Full throughput: one instruction per cycle when there is no hazard and `ex_ready=1`.
- `ex_valid` falls after an edge with `ex_ready` and no transfer.
- `rst` asserted mid-operation drops `ex_valid` and clears `pend` immediately (asynchronously). Any in-flight write-back after reset is still applied to the register file.
- `if_ready` is combinational from `ex_valid`, `ex_ready`, `flush`, `pend`, `wb_en`/`wb_addr` and `if_instr`.

## Structure
- Shared package `mips_pkg` holds:
  - Opcode constants (`OP_RTYPE`, `OP_J`, `OP_ADDI`, `OP_ANDI`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_BNE`).
  - Funct constants (`F_ADD`, `F_SUB`, `F_AND`, `F_OR`, `F_XOR`, `F_SLT`, `F_SLL`, `F_SRL`).
  - The decoded-bundle struct.
- Sub-module `reg_file`: 2 reads, 1 write, r0 hardwired to zero, write-back bypass, asynchronous reset.
- Decode logic, scoreboard and output register live in `decode_issue`.

## Test plan
- Reset, then `addi r1,r0,-4` (`0x2001FFFC`) with `ex_ready=1` → next cycle `opcode=8`, `SRC=0`, `immediateVal=0xFFFFFFFC`, `dest_addr=1`, `dest_we=1`, `pend[1]=1`.
- Back-to-back `add r3,r1,r2` after an r1 writer → `if_ready=0` until `wb_en` with `wb_addr=1`, `wb_data=5`. In that cycle the instruction transfers with `SRC=5` (bypass).
- `andi r2,r0,0x8000` → `immediateVal=0x00008000`; `j 0x3FFFFFF` → `immediateVal=0x03FFFFFF`, `dest_we=0`.
- `ex_ready=0` for 3 cycles with `if_valid=1` → bundle stable and `if_ready=0`; `ex_ready=1` → next instruction issued the following cycle.
- Opcode `0x3F`, or R-type funct `0x18` → `illegal=1`, `dest_we=0`, no `pend` bit set.
- Flush while holding `lw r4` → `ex_valid=0` and `pend[4]=0` next cycle; a subsequent read of r4 is not stalled. Asserting `rst` mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS-subset encodings and the decoded bundle handed from decode to execute.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;

   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_XOR = 6'h26;
   localparam logic [5:0] F_SLT = 6'h2A;
   localparam logic [5:0] F_SLL = 6'h00;
   localparam logic [5:0] F_SRL = 6'h02;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [31:0] src;
      logic [31:0] targ;
      logic [31:0] imm;
      logic [5:0]  funct;
      logic [4:0]  shamt;
      logic [31:0] pc;
      logic [4:0]  dest_addr;
      logic        dest_we;
      logic        mem_read;
      logic        mem_write;
      logic        illegal;
   } bundle_t;

endpackage

// File: rtl/reg_file.sv
// Two-read, one-write register file; r0 hardwired to zero, same-cycle write-back bypass.
module reg_file #(
   parameter int unsigned NREG = 32,
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      ra_addr,
   output logic [XLEN-1:0] ra_data,
   input  logic [4:0]      rb_addr,
   output logic [XLEN-1:0] rb_data,
   input  logic            we,
   input  logic [4:0]      wa,
   input  logic [XLEN-1:0] wd
);

   logic [XLEN-1:0] regs_q [NREG];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
      end else if (we && wa != 5'd0) begin
         regs_q[wa] <= wd;
      end
   end

   always_comb begin
      ra_data = '0;
      rb_data = '0;
      if (ra_addr != 5'd0) ra_data = (we && wa == ra_addr) ? wd : regs_q[ra_addr];
      if (rb_addr != 5'd0) rb_data = (we && wa == rb_addr) ? wd : regs_q[rb_addr];
   end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: decodes fetched instructions, reads operands, stalls on scoreboard
// hazards and holds the decoded bundle in a valid/ready output register toward execute.
module decode_issue
   import mips_pkg::*;
#(
   parameter int unsigned NREG = 32,
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [31:0]     if_instr,
   input  logic [31:0]     if_pc,
   input  logic            wb_en,
   input  logic [4:0]      wb_addr,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [31:0]     opcode,
   output logic [31:0]     SRC,
   output logic [31:0]     TARG,
   output logic [31:0]     immediateVal,
   output logic [5:0]      funct,
   output logic [4:0]      shamt,
   output logic [31:0]     pc,
   output logic [4:0]      dest_addr,
   output logic            dest_we,
   output logic            mem_read,
   output logic            mem_write,
   output logic            illegal
);

   logic [5:0]      op;
   logic [4:0]      rs, rt, rd;
   logic [XLEN-1:0] rs_data, rt_data;
   logic            use_rs, use_rt, writes;
   logic [4:0]      dest;
   bundle_t         dec;
   bundle_t         bundle_q;
   logic            ex_valid_q, ex_valid_d;
   logic [NREG-1:0] pend_q, pend_d, clr_mask, pend_eff;
   logic            hazard, transfer;

   assign op = if_instr[31:26];
   assign rs = if_instr[25:21];
   assign rt = if_instr[20:16];
   assign rd = if_instr[15:11];

   reg_file #(
      .NREG(NREG),
      .XLEN(XLEN)
   ) u_reg_file (
      .clk     (clk),
      .rst     (rst),
      .ra_addr (rs),
      .ra_data (rs_data),
      .rb_addr (rt),
      .rb_data (rt_data),
      .we      (wb_en),
      .wa      (wb_addr),
      .wd      (wb_data)
   );

   always_comb begin
      dec           = '0;
      dec.opcode    = op;
      dec.funct     = if_instr[5:0];
      dec.shamt     = if_instr[10:6];
      dec.pc        = if_pc;
      dec.src       = rs_data;
      dec.targ      = rt_data;
      use_rs        = 1'b1;
      use_rt        = 1'b0;
      writes        = 1'b0;
      dest          = 5'd0;
      case (op)
         OP_RTYPE: begin
            use_rt = 1'b1;
            case (if_instr[5:0])
               F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLT, F_SLL, F_SRL: begin
                  writes = 1'b1;
                  dest   = rd;
               end
               default: dec.illegal = 1'b1;
            endcase
         end
         OP_J: begin
            use_rs  = 1'b0;
            dec.imm = {6'd0, if_instr[25:0]};
         end
         OP_ADDI: begin
            dec.imm = {{16{if_instr[15]}}, if_instr[15:0]};
            writes  = 1'b1;
            dest    = rt;
         end
         OP_ANDI: begin
            dec.imm = {16'd0, if_instr[15:0]};
            writes  = 1'b1;
            dest    = rt;
         end
         OP_LW: begin
            dec.imm      = {{16{if_instr[15]}}, if_instr[15:0]};
            writes       = 1'b1;
            dest         = rt;
            dec.mem_read = 1'b1;
         end
         OP_SW: begin
            dec.imm       = {{16{if_instr[15]}}, if_instr[15:0]};
            use_rt        = 1'b1;
            dec.mem_write = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            dec.imm = {{16{if_instr[15]}}, if_instr[15:0]};
            use_rt  = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
      dec.dest_addr = dest;
      dec.dest_we   = writes && (dest != 5'd0);
   end

   // A write-back landing this cycle already resolves its register.
   always_comb begin
      clr_mask = '0;
      if (wb_en) clr_mask[wb_addr] = 1'b1;
   end
   assign pend_eff = pend_q & ~clr_mask;

   assign hazard   = (use_rs && pend_eff[rs]) || (use_rt && pend_eff[rt]) ||
                     (dec.dest_we && pend_eff[dec.dest_addr]);
   assign if_ready = (~ex_valid_q | ex_ready) & ~hazard & ~flush;
   assign transfer = if_valid & if_ready;

   always_comb begin
      pend_d = pend_eff;
      if (flush && ex_valid_q && bundle_q.dest_we) pend_d[bundle_q.dest_addr] = 1'b0;
      if (transfer && dec.dest_we) pend_d[dec.dest_addr] = 1'b1;
   end

   always_comb begin
      ex_valid_d = ex_valid_q;
      if (flush)         ex_valid_d = 1'b0;
      else if (transfer) ex_valid_d = 1'b1;
      else if (ex_ready) ex_valid_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q     <= '0;
         ex_valid_q <= 1'b0;
         bundle_q   <= '0;
      end else begin
         pend_q     <= pend_d;
         ex_valid_q <= ex_valid_d;
         if (transfer) bundle_q <= dec;
      end
   end

   assign ex_valid     = ex_valid_q;
   assign opcode       = {26'd0, bundle_q.opcode};
   assign SRC          = bundle_q.src;
   assign TARG         = bundle_q.targ;
   assign immediateVal = bundle_q.imm;
   assign funct        = bundle_q.funct;
   assign shamt        = bundle_q.shamt;
   assign pc           = bundle_q.pc;
   assign dest_addr    = bundle_q.dest_addr;
   assign dest_we      = bundle_q.dest_we;
   assign mem_read     = bundle_q.mem_read;
   assign mem_write    = bundle_q.mem_write;
   assign illegal      = bundle_q.illegal;

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: a table of single-instruction vectors plus hand sequences
// for stalls, back-pressure, flush and asynchronous reset.
module tb_decode_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid, if_ready;
   logic [31:0] if_instr, if_pc;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        flush, ex_valid, ex_ready;
   logic [31:0] opcode, SRC, TARG, immediateVal, pc;
   logic [5:0]  funct;
   logic [4:0]  shamt, dest_addr;
   logic        dest_we, mem_read, mem_write, illegal;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   decode_issue dut (
      .clk          (clk),
      .rst          (rst),
      .if_valid     (if_valid),
      .if_ready     (if_ready),
      .if_instr     (if_instr),
      .if_pc        (if_pc),
      .wb_en        (wb_en),
      .wb_addr      (wb_addr),
      .wb_data      (wb_data),
      .flush        (flush),
      .ex_valid     (ex_valid),
      .ex_ready     (ex_ready),
      .opcode       (opcode),
      .SRC          (SRC),
      .TARG         (TARG),
      .immediateVal (immediateVal),
      .funct        (funct),
      .shamt        (shamt),
      .pc           (pc),
      .dest_addr    (dest_addr),
      .dest_we      (dest_we),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .illegal      (illegal)
   );

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [5:0]  op;
      logic [31:0] src;
      logic [31:0] targ;
      logic [31:0] imm;
      logic [4:0]  dest;
      logic        we, mr, mw, ill;
   } vec_t;

   vec_t vecs[13];

   function automatic logic [31:0] regval(input int i);
      return (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_bundle(input vec_t v, input logic [31:0] epc);
      logic [31:0] ins;
      ins = v.instr;
      check({v.name, ".ex_valid"}, 32'(ex_valid), 32'd1);
      check({v.name, ".opcode"}, opcode, {26'd0, v.op});
      check({v.name, ".SRC"}, SRC, v.src);
      check({v.name, ".TARG"}, TARG, v.targ);
      check({v.name, ".imm"}, immediateVal, v.imm);
      check({v.name, ".dest_addr"}, 32'(dest_addr), 32'(v.dest));
      check({v.name, ".flags"}, {28'd0, dest_we, mem_read, mem_write, illegal},
            {28'd0, v.we, v.mr, v.mw, v.ill});
      check({v.name, ".funct"}, 32'(funct), 32'(ins[5:0]));
      check({v.name, ".shamt"}, 32'(shamt), 32'(ins[10:6]));
      check({v.name, ".pc"}, pc, epc);
   endtask

   initial begin
      //           name     instr          op     src           targ          imm          dst we mr mw il
      vecs[0]  = '{"addi",  32'h2001FFFC, 6'h08, 32'h0,        32'h10000001, 32'hFFFFFFFC, 1, 1, 0, 0, 0};
      vecs[1]  = '{"andi",  32'h30028000, 6'h0C, 32'h0,        32'h10000002, 32'h00008000, 2, 1, 0, 0, 0};
      vecs[2]  = '{"j",     32'h0BFFFFFF, 6'h02, 32'h1000001F, 32'h1000001F, 32'h03FFFFFF, 0, 0, 0, 0, 0};
      vecs[3]  = '{"lw",    32'h8C640008, 6'h23, 32'h10000003, 32'h10000004, 32'h00000008, 4, 1, 1, 0, 0};
      vecs[4]  = '{"beq",   32'h10E80010, 6'h04, 32'h10000007, 32'h10000008, 32'h00000010, 0, 0, 0, 0, 0};
      vecs[5]  = '{"bne",   32'h152AFFFF, 6'h05, 32'h10000009, 32'h1000000A, 32'hFFFFFFFF, 0, 0, 0, 0, 0};
      vecs[6]  = '{"add",   32'h00221820, 6'h00, 32'h10000001, 32'h10000002, 32'h0,        3, 1, 0, 0, 0};
      vecs[7]  = '{"sll",   32'h000C5940, 6'h00, 32'h0,        32'h1000000C, 32'h0,        11, 1, 0, 0, 0};
      vecs[8]  = '{"slt_r0",32'h0022002A, 6'h00, 32'h10000001, 32'h10000002, 32'h0,        0, 0, 0, 0, 0};
      vecs[9]  = '{"ill_fn",32'h00222818, 6'h00, 32'h10000001, 32'h10000002, 32'h0,        0, 0, 0, 0, 1};
      vecs[10] = '{"sw",    32'hACC5FFF0, 6'h2B, 32'h10000006, 32'h10000005, 32'hFFFFFFF0, 0, 0, 0, 1, 0};
      vecs[11] = '{"ill_op",32'hFC220000, 6'h3F, 32'h10000001, 32'h10000002, 32'h0,        0, 0, 0, 0, 1};
      vecs[12] = '{"xor",   32'h03DDF826, 6'h00, 32'h1000001E, 32'h1000001D, 32'h0,        31, 1, 0, 0, 0};

      rst = 1'b1; if_valid = 0; if_instr = 0; if_pc = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
      flush = 0; ex_ready = 1;
      repeat (2) @(negedge clk);
      check("rst.ex_valid", 32'(ex_valid), 32'd0);
      check("rst.opcode", opcode, 32'd0);
      check("rst.SRC", SRC, 32'd0);
      check("rst.imm", immediateVal, 32'd0);
      check("rst.pc", pc, 32'd0);
      check("rst.flags", {27'd0, dest_addr == 5'd0, dest_we, mem_read, mem_write, illegal},
            32'h10);
      check("rst.if_ready", 32'(if_ready), 32'd1);
      rst = 1'b0;

      // Preload r1..r31 with distinct values.
      for (int i = 1; i < 32; i++) begin
         @(negedge clk);
         wb_en = 1; wb_addr = 5'(i); wb_data = regval(i);
      end

      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         wb_en = 0; if_valid = 1; if_instr = vecs[k].instr; if_pc = 32'h400 + 32'(4 * k);
         #1 check({vecs[k].name, ".if_ready"}, 32'(if_ready), 32'd1);
         @(posedge clk); #1;
         check_bundle(vecs[k], 32'h400 + 32'(4 * k));
         @(negedge clk);
         if_valid = 0;
         // Retire the destination so the next vector starts with a clean scoreboard.
         wb_en = vecs[k].we; wb_addr = vecs[k].dest; wb_data = regval(int'(vecs[k].dest));
      end
      @(negedge clk); wb_en = 0;

      // RAW stall released by a same-cycle write-back, with bypass.
      if_valid = 1; if_instr = 32'h2001FFFC; if_pc = 32'h100;
      @(posedge clk); #1 check("raw.writer_we", 32'(dest_we), 32'd1);
      @(negedge clk); if_instr = 32'h00221820; if_pc = 32'h104;
      #1 check("raw.stall0", 32'(if_ready), 32'd0);
      @(negedge clk); #1 check("raw.stall1", 32'(if_ready), 32'd0);
      check("raw.ex_valid_fell", 32'(ex_valid), 32'd0);
      @(negedge clk); wb_en = 1; wb_addr = 1; wb_data = 32'd5;
      #1 check("raw.release", 32'(if_ready), 32'd1);
      @(posedge clk); #1;
      check("raw.SRC_bypass", SRC, 32'd5);
      check("raw.TARG", TARG, 32'h10000002);
      check("raw.pc", pc, 32'h104);
      @(negedge clk); if_valid = 0; wb_addr = 3; wb_data = regval(3);
      @(negedge clk); wb_addr = 1; wb_data = regval(1);
      @(negedge clk); wb_en = 0;

      // WAW: a second writer of r1 waits for the first.
      if_valid = 1; if_instr = 32'h2001FFFC; if_pc = 32'h120;
      @(negedge clk); if_instr = 32'h30010001; if_pc = 32'h124;
      #1 check("waw.stall", 32'(if_ready), 32'd0);
      @(negedge clk); wb_en = 1; wb_addr = 1; wb_data = regval(1);
      #1 check("waw.release", 32'(if_ready), 32'd1);
      @(posedge clk); #1 check("waw.imm", immediateVal, 32'd1);
      @(negedge clk); if_valid = 0;
      @(negedge clk); wb_en = 0;

      // Back-pressure: bundle holds while execute stalls.
      ex_ready = 0; if_valid = 1; if_instr = 32'h30028000; if_pc = 32'h200;
      #1 check("bp.first_ready", 32'(if_ready), 32'd1);
      @(negedge clk); if_instr = 32'h10E80010; if_pc = 32'h204;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp.if_ready", 32'(if_ready), 32'd0);
         check("bp.hold_imm", immediateVal, 32'h8000);
         check("bp.hold_pc", pc, 32'h200);
         check("bp.hold_valid", 32'(ex_valid), 32'd1);
         @(negedge clk);
      end
      ex_ready = 1;
      #1 check("bp.resume_ready", 32'(if_ready), 32'd1);
      @(posedge clk); #1;
      check("bp.next_imm", immediateVal, 32'h10);
      check("bp.next_pc", pc, 32'h204);
      @(negedge clk); if_valid = 0; wb_en = 1; wb_addr = 2; wb_data = regval(2);
      @(negedge clk); wb_en = 0;
      check("bp.valid_fell", 32'(ex_valid), 32'd0);

      // Flush of a held load releases its scoreboard bit.
      ex_ready = 0; if_valid = 1; if_instr = 32'h8C640008; if_pc = 32'h300;
      @(posedge clk); #1 check("fl.mem_read", 32'(mem_read), 32'd1);
      @(negedge clk); if_instr = 32'h00842820; if_pc = 32'h304;
      #1 check("fl.stall", 32'(if_ready), 32'd0);
      flush = 1;
      #1 check("fl.no_xfer", 32'(if_ready), 32'd0);
      @(posedge clk); #1 check("fl.ex_valid", 32'(ex_valid), 32'd0);
      @(negedge clk); flush = 0; ex_ready = 1;
      #1 check("fl.r4_free", 32'(if_ready), 32'd1);
      @(posedge clk); #1;
      check("fl.SRC", SRC, 32'h10000004);
      check("fl.dest", 32'(dest_addr), 32'd5);
      @(negedge clk); if_valid = 0; wb_en = 1; wb_addr = 5; wb_data = regval(5);
      @(negedge clk); wb_en = 0;

      // Asynchronous reset mid-stream.
      ex_ready = 0; if_valid = 1; if_instr = 32'h2001FFFC; if_pc = 32'h500;
      @(posedge clk); #1 check("ar.valid_before", 32'(ex_valid), 32'd1);
      @(negedge clk); if_valid = 0;
      #2 rst = 1;
      #1;
      check("ar.ex_valid", 32'(ex_valid), 32'd0);
      check("ar.opcode", opcode, 32'd0);
      check("ar.imm", immediateVal, 32'd0);
      check("ar.pc", pc, 32'd0);
      check("ar.dest_we", 32'(dest_we), 32'd0);
      @(negedge clk); rst = 0; ex_ready = 1; if_valid = 1; if_instr = 32'h00221820; if_pc = 32'h504;
      #1 check("ar.pend_clear", 32'(if_ready), 32'd1);
      @(posedge clk); #1;
      check("ar.SRC_zeroed", SRC, 32'd0);
      check("ar.TARG_zeroed", TARG, 32'd0);
      @(negedge clk); if_valid = 0;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
